adpcm_frame_scheduler: RTL and testbench

//  Shares one ADPCM serial link (frame + 4-bit data) among NUM_REQ requesters.

---
 rtl/adpcm_sched_pkg.sv | 12 +
 rtl/adpcm_rr_arbiter.sv | 37 +++
 rtl/adpcm_frame_scheduler.sv | 130 +++++++++++++
 tb/tb_adpcm_frame_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_sched_pkg.sv
// rtl/adpcm_sched_pkg.sv - shared types and constants for the ADPCM frame scheduler
package adpcm_sched_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } sched_state_e;

endpackage

// File: rtl/adpcm_rr_arbiter.sv
// rtl/adpcm_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module adpcm_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               gnt_valid,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0]   gnt_idx
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // Walk offsets from farthest to nearest so the closest requester to ptr wins last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      sum       = '0;
      cand      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign gnt_onehot = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/adpcm_frame_scheduler.sv
// rtl/adpcm_frame_scheduler.sv - round-robin scheduler driving one ADPCM frame/nibble link
module adpcm_frame_scheduler
   import adpcm_sched_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int FRAME_NIBBLES = 8,
   parameter int GAP_CYCLES    = 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_REQ-1:0]                      req_valid,
   input  logic [NUM_REQ*NIBBLE_W*FRAME_NIBBLES-1:0] req_data,
   output logic [NUM_REQ-1:0]                      req_ready,
   output logic                                    frame,
   output logic [NIBBLE_W-1:0]                     data,
   output logic                                    busy,
   output logic [$clog2(NUM_REQ)-1:0]              grant_id
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PAY_W = NIBBLE_W * FRAME_NIBBLES;
   localparam int CNT_W = (FRAME_NIBBLES > 1) ? $clog2(FRAME_NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(FRAME_NIBBLES - 1);
   localparam logic [3:0]       LAST_GAP = 4'(GAP_CYCLES - 1);

   sched_state_e        state_q, state_d;
   logic [PAY_W-1:0]    shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          gap_q, gap_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0]  ready_q, ready_d;
   logic                frame_q, frame_d;
   logic [NIBBLE_W-1:0] data_q, data_d;
   logic                busy_q, busy_d;

   logic                arb_valid;
   logic [NUM_REQ-1:0]  arb_onehot;
   logic [IDX_W-1:0]    arb_idx;

   adpcm_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req        (req_valid),
      .ptr        (ptr_q),
      .gnt_valid  (arb_valid),
      .gnt_onehot (arb_onehot),
      .gnt_idx    (arb_idx)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      ready_d    = '0;
      frame_d    = 1'b0;
      data_d     = '0;
      busy_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               ready_d    = arb_onehot;
               shift_d    = req_data[arb_idx*PAY_W +: PAY_W];
               grant_id_d = arb_idx;
               ptr_d      = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            // Output regs lag state by one edge, so the nibble leaves while cnt advances.
            frame_d = 1'b1;
            data_d  = shift_q[NIBBLE_W-1:0];
            shift_d = shift_q >> NIBBLE_W;
            cnt_d   = cnt_q + 1'b1;
            busy_d  = 1'b1;
            if (cnt_q == LAST_NIB) begin
               gap_d   = '0;
               state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            busy_d = 1'b1;
            gap_d  = gap_q + 1'b1;
            if (gap_q == LAST_GAP) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         gap_q      <= '0;
         ptr_q      <= '0;
         grant_id_q <= '0;
         ready_q    <= '0;
         frame_q    <= 1'b0;
         data_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         ready_q    <= ready_d;
         frame_q    <= frame_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
      end
   end

   assign req_ready = ready_q;
   assign frame     = frame_q;
   assign data      = data_q;
   assign busy      = busy_q;
   assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_adpcm_frame_scheduler.sv
// tb/tb_adpcm_frame_scheduler.sv - self-checking bench for adpcm_frame_scheduler
module tb_adpcm_frame_scheduler;

   localparam int NR = 4;
   localparam int FN = 8;
   localparam int G  = 1;
   localparam int PW = 4 * FN;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*PW-1:0] req_data = '0;
   logic [NR-1:0]    req_ready;
   logic             frame;
   logic [3:0]       data;
   logic             busy;
   logic [1:0]       grant_id;

   logic [NR-1:0]    v0 = '0;
   logic [NR*PW-1:0] d0 = '0;
   logic [NR-1:0]    r0;
   logic             f0;
   logic [3:0]       dat0;
   logic             b0;
   logic [1:0]       g0;

   always #5 clk = ~clk;

   adpcm_frame_scheduler #(.NUM_REQ(NR), .FRAME_NIBBLES(FN), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .frame(frame), .data(data), .busy(busy), .grant_id(grant_id)
   );

   adpcm_frame_scheduler #(.NUM_REQ(NR), .FRAME_NIBBLES(FN), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_data(d0),
      .req_ready(r0), .frame(f0), .data(dat0), .busy(b0), .grant_id(g0)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit vbit(input logic [NR-1:0] v, input int i);
      return 1'(v >> i);
   endfunction

   // Reference model: transaction-level view of the link, one nibble queue per frame.
   logic [NR-1:0]    pv;
   logic [NR*PW-1:0] pd;
   bit               prst = 1'b1;
   int               ptr_m = 0;
   int               lows = 100;
   logic [3:0]       mq[$];

   initial begin : monitor
      bit         exp_frame;
      bit         idle;
      bit         grant;
      logic [3:0] nib;
      logic [31:0] pay;
      int         w;
      forever begin
         @(posedge clk);
         pv   = req_valid;
         pd   = req_data;
         prst = rst;
         @(negedge clk);
         if (rst || prst) begin
            ptr_m = 0;
            lows  = 100;
            mq.delete();
         end else begin
            exp_frame = (mq.size() != 0);
            if (exp_frame) begin
               nib = mq.pop_front();
               check("mon_frame_high", 32'(frame), 32'd1);
               check("mon_nibble", 32'(data), 32'(nib));
               lows = 0;
            end else begin
               check("mon_frame_low", 32'(frame), 32'd0);
               check("mon_data_low", 32'(data), 32'd0);
               if (lows < 100) lows++;
            end
            idle  = !exp_frame && (lows >= G + 1);
            grant = idle && (pv != 4'd0);
            check("mon_ready_any", 32'(req_ready != 4'd0), 32'(grant));
            if (grant) begin
               w = ptr_m;
               while (!vbit(pv, w)) w = (w + 1) % NR;
               check("mon_ready_onehot", 32'(req_ready), 32'(4'(4'b0001 << w)));
               check("mon_grant_id", 32'(grant_id), 32'(w));
               ptr_m = (w + 1) % NR;
               pay = 32'(pd >> (w * PW));
               for (int k = 0; k < FN; k++) mq.push_back(4'(pay >> (4 * k)));
            end
            check("mon_busy", 32'(busy), 32'(exp_frame || grant || (lows >= 1 && lows <= G)));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      step(2);
      rst = 1'b0;
   endtask

   task automatic wait_ready(output logic [NR-1:0] r, input int budget);
      r = '0;
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (req_ready != 4'd0) begin
            r = req_ready;
            break;
         end
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (!busy && !frame) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   int obs_g[$];
   int obs_h[$];
   int obs_l[$];

   task automatic observe(input bit sel, input int n);
      int run = 0;
      bit prev = 1'b0;
      bit seen_high = 1'b0;
      bit f;
      obs_g.delete();
      obs_h.delete();
      obs_l.delete();
      for (int i = 0; i < n; i++) begin
         step(1);
         f = sel ? f0 : frame;
         if ((sel ? r0 : req_ready) != 4'd0) obs_g.push_back(int'(sel ? g0 : grant_id));
         if (f == prev) begin
            run++;
         end else begin
            if (prev) obs_h.push_back(run);
            else if (seen_high) obs_l.push_back(run);
            run = 1;
         end
         if (f) seen_high = 1'b1;
         prev = f;
      end
   endtask

   function automatic int qget(input int q[$], input int k);
      return (k < q.size()) ? q[k] : -1;
   endfunction

   typedef struct {
      logic [NR-1:0] valid;
      int            exp_id;
   } arb_vec_t;

   arb_vec_t tbl[8];

   initial begin : watchdog
      #400000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : main
      logic [NR-1:0] r;
      int highs;
      int readies;

      tbl[0] = '{4'b1111, 0};
      tbl[1] = '{4'b0010, 1};
      tbl[2] = '{4'b0100, 2};
      tbl[3] = '{4'b0101, 0};
      tbl[4] = '{4'b0101, 2};
      tbl[5] = '{4'b1000, 3};
      tbl[6] = '{4'b1001, 0};
      tbl[7] = '{4'b0110, 1};

      do_reset();
      check("reset_frame", 32'(frame), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_ready", 32'(req_ready), 32'd0);
      check("reset_grant_id", 32'(grant_id), 32'd0);

      // Arbitration table, including wrap and skip from pointer 3.
      foreach (tbl[e]) begin
         req_data  = {$urandom, $urandom, $urandom, $urandom};
         req_valid = tbl[e].valid;
         wait_ready(r, 40);
         check("tbl_ready", 32'(r), 32'(4'(4'b0001 << tbl[e].exp_id)));
         check("tbl_grant_id", 32'(grant_id), 32'(tbl[e].exp_id));
         req_valid = '0;
         wait_idle("tbl_idle", 40);
      end

      // Single frame, LSB nibble first, latency one after ready.
      req_data  = {32'h0, 32'h0, 32'h8765_4321, 32'h0};
      req_valid = 4'b0010;
      wait_ready(r, 40);
      check("t2_ready", 32'(r), 32'h2);
      check("t2_grant_id", 32'(grant_id), 32'd1);
      req_valid = '0;
      for (int k = 1; k <= FN; k++) begin
         step(1);
         check("t2_frame", 32'(frame), 32'd1);
         check("t2_nibble", 32'(data), 32'(k));
         check("t2_ready_low", 32'(req_ready), 32'd0);
      end
      step(1);
      check("t2_frame_end", 32'(frame), 32'd0);
      wait_idle("t2_idle", 40);

      // Async reset in the middle of a frame.
      req_valid = 4'b0100;
      wait_ready(r, 40);
      check("t1_ready", 32'(r), 32'h4);
      step(3);
      #1 rst = 1'b1;
      #1;
      check("t1_frame", 32'(frame), 32'd0);
      check("t1_data", 32'(data), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_ready", 32'(req_ready), 32'd0);
      check("t1_grant_id", 32'(grant_id), 32'd0);
      req_valid = 4'b1111;
      step(1);
      rst = 1'b0;
      wait_ready(r, 40);
      check("t1_first_grant", 32'(r), 32'h1);
      req_valid = '0;
      wait_idle("t1_idle", 40);

      // All requesters held valid: strict rotation and fixed gap.
      do_reset();
      req_data  = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
      req_valid = 4'b1111;
      observe(1'b0, 70);
      for (int k = 0; k < 5; k++) check("t3_grant_order", 32'(qget(obs_g, k)), 32'(k % NR));
      for (int k = 0; k < 4; k++) begin
         check("t3_frame_len", 32'(qget(obs_h, k)), 32'(FN));
         check("t3_low_len", 32'(qget(obs_l, k)), 32'(G + 1));
      end
      req_valid = '0;
      wait_idle("t3_idle", 40);

      // Valid dropped mid-frame: frame completes, no regrant.
      req_valid = 4'b0010;
      wait_ready(r, 40);
      check("t6_ready", 32'(r), 32'h2);
      highs   = 0;
      readies = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (i == 4) req_valid = '0;
         if (frame) highs++;
         if (req_ready != 4'd0) readies++;
      end
      check("t6_nibbles_sent", 32'(highs), 32'(FN));
      check("t6_no_regrant", 32'(readies), 32'd0);

      // Randomized requesters against the reference model.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         step(1);
         for (int i = 0; i < NR; i++) begin
            logic [NR-1:0] m;
            m = 4'(4'b0001 << i);
            if (vbit(req_valid, i) && vbit(req_ready, i)) begin
               req_valid = req_valid & ~m;
               if ($urandom_range(1, 0) == 1) begin
                  req_valid = req_valid | m;
                  req_data  = (req_data & ~({96'h0, 32'hFFFF_FFFF} << (i * PW)))
                              | ({96'h0, 32'($urandom)} << (i * PW));
               end
            end else if (!vbit(req_valid, i)) begin
               if ($urandom_range(3, 0) == 0) begin
                  req_valid = req_valid | m;
                  req_data  = (req_data & ~({96'h0, 32'hFFFF_FFFF} << (i * PW)))
                              | ({96'h0, 32'($urandom)} << (i * PW));
               end
            end else if ($urandom_range(63, 0) == 0) begin
               req_valid = req_valid & ~m;
            end
         end
      end
      req_valid = '0;
      wait_idle("rand_idle", 40);

      // Zero-gap instance: sole requester, one idle cycle between frames.
      d0 = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
      v0 = 4'b0100;
      observe(1'b1, 50);
      for (int k = 0; k < 3; k++) begin
         check("t5_grant", 32'(qget(obs_g, k)), 32'd2);
         check("t5_frame_len", 32'(qget(obs_h, k)), 32'(FN));
      end
      for (int k = 0; k < 2; k++) check("t5_low_len", 32'(qget(obs_l, k)), 32'd1);
      v0 = '0;
      step(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
